// File: rtl/axi_sevenseg_mux_ctrl.sv
// AXI4-Lite multiplexed seven-segment controller: hex decode, dp, enable mask, blink and PWM dimming.
// Optional frame interrupt (irq port, CTRL[1], STATUS[16]) is built when SEVSEG_FRAME_IRQ_EN is defined.
module axi_sevenseg_mux_ctrl #(
    parameter int NUM_DIGITS         = 8,
    parameter int SCAN_DIV           = 50000,
    parameter int BLINK_FRAMES       = 64,
    parameter int PWM_BITS           = 4,
    parameter bit ACTIVE_LOW_OUT     = 1'b1,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an
`ifdef SEVSEG_FRAME_IRQ_EN
    ,
    output logic                          irq
`endif
);

    localparam int AW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [15:0] DIG_MASK = 16'((32'd1 << NUM_DIGITS) - 32'd1);

    function automatic logic [63:0] nib_mask_f();
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < NUM_DIGITS; i++) m[4*i +: 4] = 4'hF;
        return m;
    endfunction
    localparam logic [63:0] NIB_MASK = nib_mask_f();

    function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic                 ctrl_en;
    logic [PWM_BITS-1:0]  bright;
    logic [63:0]          data_r;
    logic [15:0]          dp_r, blink_r, den_r;
    logic                 awready_r, bvalid_r, arready_r, rvalid_r;
    logic [31:0]          rdata_r;
    logic [PW-1:0]        presc;
    logic [IW-1:0]        idx;
    logic [FW-1:0]        frm;
    logic                 phase;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 irq_en, frame_flag;

    logic [(1<<AW)-1:0][31:0] regs_v;
    logic [AW-1:0]        waddr, raddr;
    logic [31:0]          wr_new;
    logic                 wr_fire, presc_tc, idx_tc, frame_wrap;

    assign waddr      = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign raddr      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire    = awready_r && S_AXI_AWVALID && S_AXI_WVALID;
    assign presc_tc   = (presc == PW'(SCAN_DIV - 1));
    assign idx_tc     = (idx == IW'(NUM_DIGITS - 1));
    assign frame_wrap = presc_tc && idx_tc;

    // Register file as seen by the bus; unmapped words stay zero.
    always_comb begin
        regs_v = '0;
        regs_v[0][0] = ctrl_en;
        regs_v[0][PWM_BITS+7:8] = bright;
`ifdef SEVSEG_FRAME_IRQ_EN
        regs_v[0][1]  = irq_en;
        regs_v[5][16] = frame_flag;
`endif
        regs_v[1] = data_r[31:0];
        regs_v[2] = data_r[63:32];
        regs_v[3] = {blink_r, dp_r};
        regs_v[4] = {16'h0, den_r};
        regs_v[5][IW-1:0] = idx;
        regs_v[5][8] = phase;
    end

    assign wr_new = merge_strb(regs_v[waddr], S_AXI_WDATA, S_AXI_WSTRB);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            awready_r <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r && !awready_r;
            if (wr_fire) bvalid_r <= 1'b1;
            else if (S_AXI_BREADY) bvalid_r <= 1'b0;
            arready_r <= S_AXI_ARVALID && !rvalid_r && !arready_r;
            if (arready_r && S_AXI_ARVALID) begin
                rvalid_r <= 1'b1;
                rdata_r  <= regs_v[raddr];
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_en <= 1'b0;
            bright  <= '0;
            irq_en  <= 1'b0;
            data_r  <= '0;
            dp_r    <= '0;
            blink_r <= '0;
            den_r   <= DIG_MASK;
        end else if (wr_fire) begin
            case (waddr)
                AW'(0): begin
                    ctrl_en <= wr_new[0];
                    bright  <= wr_new[PWM_BITS+7:8];
`ifdef SEVSEG_FRAME_IRQ_EN
                    irq_en  <= wr_new[1];
`endif
                end
                AW'(1): data_r[31:0]    <= wr_new & NIB_MASK[31:0];
                AW'(2): data_r[63:32]   <= wr_new & NIB_MASK[63:32];
                AW'(3): {blink_r, dp_r} <= wr_new & {DIG_MASK, DIG_MASK};
                AW'(4): den_r           <= wr_new[15:0] & DIG_MASK;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            presc      <= '0;
            idx        <= '0;
            frm        <= '0;
            phase      <= 1'b0;
            pwm_cnt    <= '0;
            frame_flag <= 1'b0;
        end else begin
            presc   <= presc_tc ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (presc_tc) idx <= idx_tc ? '0 : idx + 1'b1;
            if (frame_wrap) begin
                frm <= (frm == FW'(BLINK_FRAMES - 1)) ? '0 : frm + 1'b1;
                if (frm == FW'(BLINK_FRAMES - 1)) phase <= ~phase;
            end
`ifdef SEVSEG_FRAME_IRQ_EN
            // Set has priority over a software clear in the same cycle.
            if (frame_wrap) frame_flag <= 1'b1;
            else if (wr_fire && waddr == AW'(5) && S_AXI_WSTRB[2] && S_AXI_WDATA[16])
                frame_flag <= 1'b0;
`endif
        end
    end

    logic                  lit, vis;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;

    assign lit   = (&bright) || (pwm_cnt < bright);
    assign vis   = ctrl_en && den_r[idx] && lit && !(blink_r[idx] && phase);
    assign an_n  = vis ? (NUM_DIGITS'(1) << idx) : '0;
    assign seg_n = vis ? hex7(data_r[{idx, 2'b00} +: 4]) : 7'h0;
    assign dp_n  = vis && dp_r[idx];

    // Polarity is applied at the flop so the pins never glitch through the decode.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            an  <= {NUM_DIGITS{ACTIVE_LOW_OUT}};
            seg <= {7{ACTIVE_LOW_OUT}};
            dp  <= ACTIVE_LOW_OUT;
        end else begin
            an  <= an_n ^ {NUM_DIGITS{ACTIVE_LOW_OUT}};
            seg <= seg_n ^ {7{ACTIVE_LOW_OUT}};
            dp  <= dp_n ^ ACTIVE_LOW_OUT;
        end
    end

`ifdef SEVSEG_FRAME_IRQ_EN
    assign irq = frame_flag && irq_en;
`endif

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = awready_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_r;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_new, irq_en, frame_flag};

endmodule

// File: doc/axi_sevenseg_mux_ctrl.md
Name: axi_sevenseg_mux_ctrl

Overview:
- Parametrised successor to the team's eight-digit AXI4-Lite seven-segment peripheral.
- Drives up to 16 multiplexed digits; digit count is a parameter.
- Adds per-digit hex decode, decimal points, digit-enable mask, per-digit blink and PWM brightness.
- Sits behind the AXI4-Lite interconnect as a slave; pins go straight to board anodes and segments.

Parameters:
- NUM_DIGITS, 8, digits driven (1..16).
- SCAN_DIV, 50000, ACLK cycles per digit slot (>=2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).
- PWM_BITS, 4, brightness resolution.
- ACTIVE_LOW_OUT, 1, 1 = seg/dp/an active-low at pins.
- C_S_AXI_ADDR_WIDTH, 5, AXI address width.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH;  S_AXI_AWVALID in 1;  S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32;  S_AXI_WSTRB in 4;  S_AXI_WVALID in 1;  S_AXI_WREADY out 1.
- S_AXI_BRESP out 2;  S_AXI_BVALID out 1;  S_AXI_BREADY in 1.
- S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH;  S_AXI_ARVALID in 1;  S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32;  S_AXI_RRESP out 2;  S_AXI_RVALID out 1;  S_AXI_RREADY in 1.
- seg  out  7  segments a..g (bit0 = a).
- dp  out  1  decimal point.
- an  out  NUM_DIGITS  one-hot digit select.

Behaviour:
- Register map (word-aligned; AWPROT/ARPROT not used):
  - 0x00 CTRL: [0] enable; [PWM_BITS+7:8] brightness.
  - 0x04 DATA_LO: nibble i = digit i, i = 0..7.
  - 0x08 DATA_HI: nibble i = digit i+8.
  - 0x0C DP_BLINK: [15:0] decimal points; [31:16] blink mask.
  - 0x10 DIGIT_EN: [15:0], one bit per digit.
  - 0x14 STATUS (RO): [3:0] current digit; [8] blink phase.
- Bits at or above NUM_DIGITS in any per-digit field read 0 and are ignored.
- Unmapped reads return 0. Writes to RO or unmapped addresses are ignored. BRESP and RRESP are always 00.
- Reset values: all registers 0; DIGIT_EN = all ones for the implemented digits.
- Write channel:
  - Accept when AWVALID && WVALID && !BVALID; AWREADY and WREADY pulse high together for 1 cycle.
  - Register update uses WSTRB byte lanes.
  - BVALID rises the next cycle and holds until BREADY.
- Read channel:
  - Accept when ARVALID && !RVALID; ARREADY pulses for 1 cycle.
  - RDATA and RVALID are registered the next cycle and held until RREADY.
  - A read in the same cycle as a write returns the old value.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count the digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - Each wrap is one frame. Frame counter 0..BLINK_FRAMES-1; at terminal count the blink phase toggles.
  - Prescaler, index, frame counter and phase run regardless of enable.
- PWM:
  - PWM_BITS counter free-runs every ACLK.
  - Lit = pwm_cnt < brightness, or brightness = all ones (always lit). Brightness 0 = dark.
- Digit visible when all hold: enable, DIGIT_EN[idx], lit, and NOT (blink[idx] && phase = 1).
- Outputs:
  - Visible digit: an = one-hot idx; seg = hex decode of nibble (0-F standard a..g patterns, e.g. 0 -> 0x3F, 8 -> 0x7F, F -> 0x71); dp = DP[idx].
  - Otherwise an, seg and dp are all inactive.
  - Outputs are registered: 1-cycle latency from index/PWM change. ACTIVE_LOW_OUT inverts all three at the final flop.
- Reset: asynchronous assert drives all outputs inactive (an/seg/dp = all ones when ACTIVE_LOW_OUT=1), BVALID = RVALID = 0, and clears all counters. Reset mid-transaction abandons it with no response.
- Boundaries:
  - Register writes take effect on the next output register update, with no waiting for the frame boundary.
  - NUM_DIGITS=1: index stays 0 and each prescaler wrap is a frame.

Optional Feature:
- SEVSEG_FRAME_IRQ_EN defined:
  - Adds output port irq (1 bit).
  - Sticky STATUS[16] sets on each frame wrap; irq = STATUS[16] && CTRL[1].
  - Writing 1 to STATUS[16] clears it. If a set and a clear land in the same cycle, set wins.
- Undefined: no irq port; CTRL[1] and STATUS[16] read 0.

Test Plan:
- Reset, then read all registers -> CTRL=0, DATA=0, DIGIT_EN=0x00FF (NUM_DIGITS=8), BRESP/RRESP=00. During reset an=0xFF, seg=0x7F, dp=1.
- SCAN_DIV=4: write DATA_LO=0x76543210, CTRL=0x0F01 -> an steps through 0xFE, 0xFD, ... every 4 cycles. seg = ~0x3F for digit0 and ~0x06 for digit1; wraps after digit7.
- Write with WSTRB=0b0010 data 0xAAAAAAAA to DATA_LO -> reads back 0x7654AA10.
- Brightness=4, PWM_BITS=4 -> an active exactly 4 of every 16 cycles within each slot. Brightness=0 -> an stays 0xFF.
- BLINK_FRAMES=2, blink mask=0x0001 -> digit0 dark during alternate 2-frame windows, other digits unaffected. DIGIT_EN=0xFE -> digit0 never active.
- Hold BREADY=0 for 10 cycles with AWVALID/WVALID high -> BVALID stays high and no second write is accepted; write to 0x18 -> OKAY and no register change.
